// File: rtl/mem_arb_pkg.sv
// Shared definitions for the three-port memory arbiter.
//   NREQ              : number of requesters (ifetch, data, debug loader)
//   IFETCH/DATA/DEBUG : requester index constants
//   arb_state_e       : arbiter FSM state encoding
//   rr_next           : round-robin successor of a requester index
//   oh_to_idx         : one-hot requester vector to index
package mem_arb_pkg;

  localparam int NREQ   = 3;
  localparam int IFETCH = 0;
  localparam int DATA   = 1;
  localparam int DEBUG  = 2;

  // Last winner after reset is DEBUG, so IFETCH has first priority.
  localparam logic [1:0] LAST_RESET = 2'(DEBUG);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    rr_next = (idx == 2'(NREQ - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [1:0] oh_to_idx(input logic [NREQ-1:0] oh);
    oh_to_idx = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) oh_to_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req_i  : per-requester request vector
//   last_i : index of the previous winner
//   pick_o : one-hot winner; search starts at the requester after last_i
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      last_i,
  output logic [NREQ-1:0] pick_o
);

  logic [1:0] cand1, cand2, cand3;

  always_comb begin
    cand1  = rr_next(last_i);
    cand2  = rr_next(cand1);
    cand3  = rr_next(cand2);
    pick_o = '0;
    if (req_i[cand1])      pick_o[cand1] = 1'b1;
    else if (req_i[cand2]) pick_o[cand2] = 1'b1;
    else if (req_i[cand3]) pick_o[cand3] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between three
// requesters (ifetch, data, debug loader). One transaction at a time:
// IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> DONE -> IDLE.
//   clk, reset        : clock, synchronous active-high reset
//   req_i/we_i        : per-requester request and write enable
//   addr_i/wdata_i    : per-requester address/data, requester n at [n*W +: W]
//   gnt_o             : one-hot pulse in the ISSUE cycle
//   done_o            : one-hot completion pulse in the DONE cycle
//   rdata_o           : last read data, held until the next read completes
//   mem_en_o..mem_wdata_o : single-port memory command (ISSUE cycle only)
//   mem_rdata_i       : memory read data, valid RD_LAT cycles after mem_en_o
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    done_o,
  output logic [DW-1:0]      rdata_o,
  output logic               mem_en_o,
  output logic               mem_we_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [DW-1:0]      mem_wdata_o,
  input  logic [DW-1:0]      mem_rdata_i
);

  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  arb_state_e        state_q;
  logic [1:0]        last_q;
  logic [1:0]        cnt_q;
  logic [NREQ-1:0]   win_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic [DW-1:0]     rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [AW-1:0]     mem_addr_q;
  logic [DW-1:0]     mem_wdata_q;

  logic [NREQ-1:0]   pick_d;
  logic [1:0]        last_d;
  logic              we_d;
  logic [AW-1:0]     addr_d;
  logic [DW-1:0]     wdata_d;

  rr_pick u_rr_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .pick_o (pick_d)
  );

  // Mux the winner's command fields; pick_d is one-hot or zero.
  always_comb begin
    last_d  = oh_to_idx(pick_d);
    we_d    = we_i[0];
    addr_d  = addr_i[0 +: AW];
    wdata_d = wdata_i[0 +: DW];
    for (int n = 1; n < NREQ; n++) begin
      if (pick_d[n]) begin
        we_d    = we_i[n];
        addr_d  = addr_i[n*AW +: AW];
        wdata_d = wdata_i[n*DW +: DW];
      end
    end
  end

  // The mem_*_q registers double as the latched command of the transaction,
  // so mem_we_q still tells ISSUE whether to go to DONE or WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= LAST_RESET;
      cnt_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      gnt_q    <= '0;
      done_q   <= '0;
      mem_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_i) begin
            win_q       <= pick_d;
            last_q      <= last_d;
            gnt_q       <= pick_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= we_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_we_q) begin
            done_q  <= win_q;
            state_q <= ST_DONE;
          end else begin
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            rdata_q <= mem_rdata_i;
            done_q  <= win_q;
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT=1 and RD_LAT=4) run the
// same scenarios side by side against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int ND = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst   [ND];
  logic [2:0]      req   [ND];
  logic [2:0]      we    [ND];
  logic [3*AW-1:0] addr  [ND];
  logic [3*DW-1:0] wdata [ND];
  logic [2:0]      gnt   [ND];
  logic [2:0]      done  [ND];
  logic [DW-1:0]   rdat  [ND];
  logic            men   [ND];
  logic            mwe   [ND];
  logic [AW-1:0]   maddr [ND];
  logic [DW-1:0]   mwd   [ND];
  logic [DW-1:0]   mrd   [ND];

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .gnt_o(gnt[0]), .done_o(done[0]), .rdata_o(rdat[0]),
    .mem_en_o(men[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]),
    .mem_wdata_o(mwd[0]), .mem_rdata_i(mrd[0])
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(4)) u_lat4 (
    .clk(clk), .reset(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .gnt_o(gnt[1]), .done_o(done[1]), .rdata_o(rdat[1]),
    .mem_en_o(men[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]),
    .mem_wdata_o(mwd[1]), .mem_rdata_i(mrd[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit rand_mode = 1'b0;

  // Memory behind each DUT, and the model's own view of the same memory.
  logic [DW-1:0] mem     [ND][256];
  logic [DW-1:0] ref_mem [ND][256];
  bit            pend_v    [ND];
  int            pend_due  [ND];
  logic [DW-1:0] pend_data [ND];

  // Transaction-level model: age counts cycles since acceptance (ISSUE = 1).
  bit            m_busy  [ND];
  int            m_age   [ND];
  int            m_win   [ND];
  bit            m_we    [ND];
  logic [AW-1:0] m_addr  [ND];
  logic [DW-1:0] m_wdata [ND];
  int            m_last  [ND];
  logic [DW-1:0] m_rdata [ND];
  bit            m_rchk  [ND];

  bit [2:0] granted [ND];
  int       g_cyc   [ND];
  int       d_cyc   [ND];
  int       en_cnt  [ND];
  int       gorder  [ND][$];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int oh2i(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input int d);
    int dl;
    if (rst[d]) begin
      m_busy[d] = 1'b0; m_last[d] = 2; m_rdata[d] = '0; m_rchk[d] = 1'b1;
      return;
    end
    m_rchk[d] = 1'b0;
    if (m_busy[d]) begin
      dl = m_we[d] ? 2 : 2 + lat(d);
      if (m_age[d] == dl) m_busy[d] = 1'b0;
      else begin
        m_age[d]++;
        if (m_age[d] == dl && !m_we[d]) m_rdata[d] = ref_mem[d][m_addr[d][7:0]];
      end
    end else if (req[d] != 3'b000) begin
      for (int off = 1; off <= 3; off++) begin
        int i;
        i = (m_last[d] + off) % 3;
        if (req[d][i]) begin m_win[d] = i; break; end
      end
      m_last[d]  = m_win[d];
      m_we[d]    = we[d][m_win[d]];
      m_addr[d]  = addr[d][m_win[d]*AW +: AW];
      m_wdata[d] = wdata[d][m_win[d]*DW +: DW];
      m_busy[d]  = 1'b1;
      m_age[d]   = 1;
      if (m_we[d]) ref_mem[d][m_addr[d][7:0]] = m_wdata[d];
    end
  endtask

  task automatic check_outputs(input int d);
    logic [2:0] eg, ed;
    int dl;
    dl = m_we[d] ? 2 : 2 + lat(d);
    eg = (m_busy[d] && m_age[d] == 1)  ? 3'(1 << m_win[d]) : 3'b000;
    ed = (m_busy[d] && m_age[d] == dl) ? 3'(1 << m_win[d]) : 3'b000;
    chk($sformatf("d%0d gnt", d), gnt[d], eg);
    chk($sformatf("d%0d done", d), done[d], ed);
    chk($sformatf("d%0d mem_en", d), men[d], (eg != 3'b000));
    chk($sformatf("d%0d rdata", d), rdat[d], m_rdata[d]);
    if (eg != 3'b000) begin
      chk($sformatf("d%0d mem_we", d), mwe[d], m_we[d]);
      chk($sformatf("d%0d mem_addr", d), maddr[d], m_addr[d]);
      chk($sformatf("d%0d mem_wdata", d), mwd[d], m_wdata[d]);
    end
    if (m_rchk[d]) begin
      chk($sformatf("d%0d rst mem_we", d), mwe[d], 0);
      chk($sformatf("d%0d rst mem_addr", d), maddr[d], 0);
      chk($sformatf("d%0d rst mem_wdata", d), mwd[d], 0);
    end
  endtask

  // Memory reacts to the command seen this cycle; read data is presented
  // only in the cycle it is due, random junk otherwise.
  task automatic mem_resp(input int d);
    if (men[d] === 1'b1) begin
      if (mwe[d]) mem[d][maddr[d][7:0]] = mwd[d];
      else begin
        pend_v[d] = 1'b1; pend_due[d] = cyc + lat(d); pend_data[d] = mem[d][maddr[d][7:0]];
      end
    end
    if (pend_v[d] && pend_due[d] == cyc) begin
      mrd[d] = pend_data[d]; pend_v[d] = 1'b0;
    end else mrd[d] = $urandom;
  endtask

  task automatic new_req(input int d, input int n);
    req[d][n] = 1'b1;
    we[d][n]  = 1'($urandom_range(1, 0));
    addr[d][n*AW +: AW]  = AW'($urandom_range(63, 0));
    wdata[d][n*DW +: DW] = $urandom;
    granted[d][n] = 1'b0;
  endtask

  task automatic gen(input int d);
    for (int n = 0; n < 3; n++) begin
      if (gnt[d][n]) granted[d][n] = 1'b1;
      if (req[d][n]) begin
        if (done[d][n]) begin
          granted[d][n] = 1'b0;
          if ($urandom_range(1, 0) == 1) new_req(d, n); else req[d][n] = 1'b0;
        end else if (!granted[d][n] && $urandom_range(19, 0) == 0) req[d][n] = 1'b0;
      end else if ($urandom_range(3, 0) == 0) new_req(d, n);
    end
  endtask

  // Inputs for the current cycle are already set; step the model, move to
  // the next cycle's falling edge, check, then respond and (maybe) drive.
  task automatic tick();
    for (int d = 0; d < ND; d++) model_step(d);
    @(negedge clk);
    cyc++;
    for (int d = 0; d < ND; d++) begin
      check_outputs(d);
      mem_resp(d);
      if (rand_mode) gen(d);
    end
  endtask

  task automatic do_reset();
    for (int d = 0; d < ND; d++) begin rst[d] = 1'b1; req[d] = 3'b000; granted[d] = 3'b000; end
    tick(); tick();
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;
  endtask

  task automatic run(input bit hold, input int ngr, input int max_cyc);
    int t;
    bit fin;
    for (int d = 0; d < ND; d++) begin
      g_cyc[d] = -1; d_cyc[d] = -1; en_cnt[d] = 0; gorder[d].delete();
    end
    t = 0; fin = 1'b0;
    while (!fin && t < max_cyc) begin
      tick(); t++;
      for (int d = 0; d < ND; d++) begin
        if (gnt[d] != 3'b000) begin
          if (g_cyc[d] < 0) g_cyc[d] = cyc;
          gorder[d].push_back(oh2i(gnt[d]));
        end
        if (men[d]) en_cnt[d]++;
        if (done[d] != 3'b000) begin
          d_cyc[d] = cyc;
          if (!hold) req[d] = req[d] & ~done[d];
        end
      end
      fin = 1'b1;
      for (int d = 0; d < ND; d++)
        if (hold ? (gorder[d].size() < ngr) : (req[d] != 3'b000)) fin = 1'b0;
    end
    chk("run_bound", 64'(fin), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int seen_done;
    int order_exp [6] = '{0, 1, 2, 0, 1, 2};
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; req[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0; mrd[d] = '0;
      pend_v[d] = 1'b0; granted[d] = '0;
      for (int i = 0; i < 256; i++) begin
        logic [DW-1:0] v;
        v = $urandom; mem[d][i] = v; ref_mem[d][i] = v;
      end
    end
    do_reset();
    idle(2);

    // Single read by ifetch at 0x0010.
    for (int d = 0; d < ND; d++) begin
      mem[d][8'h10] = 32'hDEADBEEF; ref_mem[d][8'h10] = 32'hDEADBEEF;
      req[d] = 3'b001; we[d] = 3'b000; addr[d][0 +: AW] = 16'h0010;
    end
    run(1'b0, 0, 40);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d rd first gnt", d), gorder[d].size() > 0 ? gorder[d][0] : -1, 0);
      chk($sformatf("d%0d rd gnt->done", d), d_cyc[d] - g_cyc[d], 1 + lat(d));
      chk($sformatf("d%0d rd mem_en cnt", d), en_cnt[d], 1);
      chk($sformatf("d%0d rd data", d), rdat[d], 32'hDEADBEEF);
    end
    idle(1);

    // Data port writes 0x12345678 to 0x0020; rdata must hold.
    for (int d = 0; d < ND; d++) begin
      req[d] = 3'b010; we[d] = 3'b010;
      addr[d][AW +: AW] = 16'h0020; wdata[d][DW +: DW] = 32'h12345678;
    end
    run(1'b0, 0, 40);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d wr gnt->done", d), d_cyc[d] - g_cyc[d], 1);
      chk($sformatf("d%0d wr mem_en cnt", d), en_cnt[d], 1);
      chk($sformatf("d%0d wr rdata held", d), rdat[d], 32'hDEADBEEF);
      chk($sformatf("d%0d wr mem", d), mem[d][8'h20], 32'h12345678);
    end
    idle(1);

    // All three requesting continuously after reset: strict rotation.
    do_reset();
    for (int d = 0; d < ND; d++) begin req[d] = 3'b111; we[d] = 3'b000; end
    run(1'b1, 6, 200);
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 6; i++)
        chk($sformatf("d%0d rr order %0d", d, i),
            gorder[d].size() > i ? gorder[d][i] : -1, order_exp[i]);
    for (int d = 0; d < ND; d++) req[d] = 3'b000;
    idle(10);

    // Reset during the WAIT of a debug-loader read.
    for (int d = 0; d < ND; d++) begin req[d] = 3'b100; we[d] = 3'b000; addr[d][2*AW +: AW] = 16'h0030; end
    begin
      int t;
      t = 0;
      while (gnt[0] != 3'b100 && t < 10) begin tick(); t++; end
      chk("dbg gnt seen", gnt[0], 3'b100);
    end
    tick();
    for (int d = 0; d < ND; d++) begin rst[d] = 1'b1; req[d] = 3'b000; end
    tick();
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      for (int d = 0; d < ND; d++) if (done[d] != 3'b000) seen_done++;
    end
    chk("no done after reset", seen_done, 0);
    for (int d = 0; d < ND; d++) begin req[d] = 3'b111; we[d] = 3'b000; end
    run(1'b1, 1, 20);
    for (int d = 0; d < ND; d++)
      chk($sformatf("d%0d post-rst first gnt", d), gorder[d].size() > 0 ? gorder[d][0] : -1, 0);
    for (int d = 0; d < ND; d++) req[d] = 3'b000;
    idle(10);

    // Randomized traffic against the model.
    do_reset();
    rand_mode = 1'b1;
    idle(3000);
    rand_mode = 1'b0;
    for (int d = 0; d < ND; d++) req[d] = 3'b000;
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, memory word-address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter RD_LAT, default 1, memory read latency in cycles, legal range 1..4.
REQ-004 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port req_i, input, 3, per-requester request (bit0 ifetch, bit1 data, bit2 debug loader).
REQ-007 SHALL have port we_i, input, 3, per-requester write enable.
REQ-008 SHALL have port addr_i, input, 3*AW, per-requester address, requester n at [n*AW +: AW].
REQ-009 SHALL have port wdata_i, input, 3*DW, per-requester write data, requester n at [n*DW +: DW].
REQ-010 SHALL have port gnt_o, output, 3, one-hot pulse marking the accepted requester.
REQ-011 SHALL have port done_o, output, 3, one-hot completion pulse.
REQ-012 SHALL have port rdata_o, output, DW, read data, valid while done_o is non-zero for a read.
REQ-013 SHALL have ports mem_en_o (output, 1), mem_we_o (output, 1), mem_addr_o (output, AW) and mem_wdata_o (output, DW), the single-port memory command.
REQ-014 SHALL have port mem_rdata_i, input, DW, memory read data, valid RD_LAT cycles after the mem_en_o cycle.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT and DONE; all outputs registered.
REQ-016 In IDLE with req_i != 0 at edge k, SHALL pick a winner, latch its we/addr/wdata, and enter ISSUE.
REQ-017 In ISSUE (cycle k+1), SHALL drive gnt_o[winner]=1 and mem_en_o=1 for exactly one cycle, with mem_we_o, mem_addr_o and mem_wdata_o from the latched values.
REQ-018 For a write, ISSUE SHALL go to DONE, so done_o[winner]=1 in cycle k+2.
REQ-019 For a read, ISSUE SHALL go to WAIT; WAIT SHALL count RD_LAT cycles, capture mem_rdata_i on the final WAIT edge, then enter DONE, so done_o is asserted in cycle k+2+RD_LAT with rdata_o valid.
REQ-020 DONE SHALL last one cycle and return to IDLE; rdata_o SHALL hold its value until the next read completes.
REQ-021 Winner SHALL be chosen round-robin: search starts at the requester after the last winner, modulo 3; the initial last winner is 2, so requester 0 has first priority after reset.
REQ-022 Simultaneous requests SHALL produce exactly one grant; any pending requester SHALL be served within 3 transactions.
REQ-023 Requesters SHALL hold req/we/addr/wdata until done; a req still high in the cycle after its done SHALL be treated as a new request.
REQ-024 A req dropped in IDLE before selection SHALL be ignored; a req dropped after selection SHALL not abort the transaction.
REQ-025 mem_en_o SHALL be 0 in IDLE, WAIT and DONE; there SHALL be at most one outstanding memory transaction.
REQ-026 A write SHALL leave rdata_o unchanged.

Reset
REQ-027 reset SHALL force state IDLE, last winner 2, WAIT counter 0, and gnt_o, done_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o and rdata_o all to 0.
REQ-028 reset asserted mid-transaction SHALL abandon it with no done pulse; a late mem_rdata_i SHALL be ignored.
REQ-029 Arbitration SHALL resume on the first edge after reset is deasserted.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the state encoding, NREQ=3 and the requester index constants (IFETCH=0, DATA=1, DEBUG=2).
REQ-031 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and last winner; output one-hot pick), instantiated once.

Verification
REQ-032 After reset, single read by requester 0 at addr 0x0010, RD_LAT=1, memory returns 0xDEADBEEF -> gnt_o=001 in cycle k+1, done_o=001 in cycle k+3, rdata_o=0xDEADBEEF.
REQ-033 Requester 1 writes 0x12345678 to 0x0020 -> mem_en_o=1, mem_we_o=1 and mem_addr_o=0x0020 for one cycle; done_o=010 in cycle k+2; rdata_o unchanged.
REQ-034 req_i=111 held continuously after reset -> grant order 0,1,2,0,1,2, one gnt_o bit per transaction.
REQ-035 RD_LAT=4 read -> no mem_en_o during the 4 WAIT cycles; done_o in cycle k+6.
REQ-036 reset pulsed during WAIT of a requester-2 read -> no done_o, all outputs 0; the next request is granted with requester 0 first priority.
